// File: rtl/stft_pkg.sv
// Types and constants shared by the STFT analysis/synthesis blocks
// (hannifier, iffter, overlap_adder, output_writer).
package stft_pkg;

    localparam int unsigned WINDOW_LEN = 4096;
    localparam int unsigned HOP        = 1024;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned SAMPLE_W   = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic        [SAMPLE_W-1:0] coef_t;
    typedef logic        [ADDR_W-1:0]   addr_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam addr_t LAST_IDX   = addr_t'(WINDOW_LEN - 1);
    // Indices from here on land in ring slots that only hold stale data.
    localparam addr_t BYPASS_IDX = addr_t'(WINDOW_LEN - HOP);

endpackage

// File: rtl/hann_mac.sv
// Windowing multiply (Q1.15 x Q0.16 -> Q1.15) followed by a saturating
// overlap-add into the accumulator, with a registered result.
module hann_mac
    import stft_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  sample_t sample,
    input  coef_t   coef,
    input  sample_t acc,
    input  logic    bypass,
    output sample_t wdata
);

    logic signed [32:0] prod;
    sample_t            p;
    logic signed [16:0] sum;
    sample_t            result;

    always_comb begin
        prod = sample * $signed({1'b0, coef});
        // Arithmetic shift keeps floor rounding; the result always fits 16 bits.
        p    = sample_t'(prod >>> 16);
        sum  = {acc[15], acc} + {p[15], p};
        if (bypass) begin
            result = p;
        end else if (sum[16] != sum[15]) begin
            result = sum[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            result = sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdata <= '0;
        end else begin
            wdata <= result;
        end
    end

endmodule

// File: rtl/overlap_adder.sv
// Windows each post-IFFT frame with the Hann ROM and overlap-adds it into the
// output ring at the frame's hop position, then hands the final hop onward.
module overlap_adder
    import stft_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    go_in,
    input  addr_t   window_start,
    input  sample_t ifft_buf_data,
    output addr_t   ifft_buf_addr,
    input  coef_t   hann_rom_data,
    output addr_t   hann_rom_addr,
    input  sample_t out_ring_rdata,
    output addr_t   out_ring_raddr,
    output addr_t   out_ring_waddr,
    output sample_t out_ring_wdata,
    output logic    out_ring_wren,
    output logic    go_out,
    output addr_t   ready_start,
    output logic    busy,
    output logic    overrun
);

    state_t state_q, state_d;
    addr_t  idx_q, idx_d;
    addr_t  start_q, start_d;
    addr_t  ready_q, ready_d;
    logic   drain_q, drain_d;
    logic   overrun_q, overrun_d;

    logic   v1_q, byp1_q, wren_q;
    addr_t  waddr1_q, waddr_q;
    addr_t  raddr;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        start_d   = start_q;
        ready_d   = ready_q;
        drain_d   = drain_q;
        overrun_d = overrun_q;
        if (go_in && state_q != IDLE) begin
            overrun_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (go_in) begin
                    start_d = window_start;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx_q == LAST_IDX) begin
                    drain_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + addr_t'(1);
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    ready_d = start_q;
                    state_d = DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            start_q   <= '0;
            ready_q   <= '0;
            drain_q   <= 1'b0;
            overrun_q <= 1'b0;
            v1_q      <= 1'b0;
            byp1_q    <= 1'b0;
            waddr1_q  <= '0;
            wren_q    <= 1'b0;
            waddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            start_q   <= start_d;
            ready_q   <= ready_d;
            drain_q   <= drain_d;
            overrun_q <= overrun_d;
            // Stage 1 tracks the read in flight, stage 2 aligns with hann_mac.
            v1_q      <= (state_q == RUN);
            byp1_q    <= (idx_q >= BYPASS_IDX);
            waddr1_q  <= raddr;
            wren_q    <= v1_q;
            waddr_q   <= waddr1_q;
        end
    end

    assign raddr = start_q + idx_q;

    hann_mac u_hann_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .sample (ifft_buf_data),
        .coef   (hann_rom_data),
        .acc    (out_ring_rdata),
        .bypass (byp1_q),
        .wdata  (out_ring_wdata)
    );

    assign ifft_buf_addr  = idx_q;
    assign hann_rom_addr  = idx_q;
    assign out_ring_raddr = raddr;
    assign out_ring_waddr = waddr_q;
    assign out_ring_wren  = wren_q;
    assign go_out         = (state_q == DONE);
    assign ready_start    = ready_q;
    assign busy           = (state_q != IDLE);
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_overlap_adder.sv
// Directed bench for overlap_adder with behavioural 1-cycle-latency memories.
module tb_overlap_adder;
    import stft_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n;
    logic    go_in;
    addr_t   window_start;
    sample_t ifft_buf_data;
    addr_t   ifft_buf_addr;
    coef_t   hann_rom_data;
    addr_t   hann_rom_addr;
    sample_t out_ring_rdata;
    addr_t   out_ring_raddr;
    addr_t   out_ring_waddr;
    sample_t out_ring_wdata;
    logic    out_ring_wren;
    logic    go_out;
    addr_t   ready_start;
    logic    busy;
    logic    overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wren_cnt = 0;
    int go_cnt   = 0;

    logic [15:0] ifft_mem [WINDOW_LEN];
    logic [15:0] hann_mem [WINDOW_LEN];
    logic [15:0] ring_mem [WINDOW_LEN];
    logic [15:0] ifft_q, hann_q, ring_q;
    logic        rnd_en = 1'b0;
    logic [15:0] rnd_a, rnd_b, rnd_c;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_ring_wren) wren_cnt <= wren_cnt + 1;
        if (go_out) go_cnt <= go_cnt + 1;
        ifft_q <= ifft_mem[ifft_buf_addr];
        hann_q <= hann_mem[hann_rom_addr];
        ring_q <= ring_mem[out_ring_raddr];
        if (out_ring_wren) ring_mem[out_ring_waddr] <= out_ring_wdata;
    end

    assign ifft_buf_data  = rnd_en ? rnd_a : ifft_q;
    assign hann_rom_data  = rnd_en ? rnd_b : hann_q;
    assign out_ring_rdata = rnd_en ? rnd_c : ring_q;

    overlap_adder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .go_in          (go_in),
        .window_start   (window_start),
        .ifft_buf_data  (ifft_buf_data),
        .ifft_buf_addr  (ifft_buf_addr),
        .hann_rom_data  (hann_rom_data),
        .hann_rom_addr  (hann_rom_addr),
        .out_ring_rdata (out_ring_rdata),
        .out_ring_raddr (out_ring_raddr),
        .out_ring_waddr (out_ring_waddr),
        .out_ring_wdata (out_ring_wdata),
        .out_ring_wren  (out_ring_wren),
        .go_out         (go_out),
        .ready_start    (ready_start),
        .busy           (busy),
        .overrun        (overrun)
    );

    task automatic preload(input logic [15:0] ring_v, input logic [15:0] ifft_v,
                           input logic [15:0] hann_v);
        for (int i = 0; i < WINDOW_LEN; i++) begin
            ring_mem[i] = ring_v;
            ifft_mem[i] = ifft_v;
            hann_mem[i] = hann_v;
        end
    endtask

    task automatic start_window(input addr_t ws, output int c0);
        @(negedge clk);
        window_start = ws;
        go_in = 1'b1;
        c0 = cyc;
        @(negedge clk);
        go_in = 1'b0;
    endtask

    // Waits (bounded) for go_out; reports its cycle and the first wren cycle seen.
    task automatic wait_go(output bit ok, output int gcyc, output int fw, output addr_t rs);
        ok = 1'b0; gcyc = -1; fw = -1; rs = '0;
        for (int k = 0; k < 6000; k++) begin
            if (out_ring_wren && fw < 0) fw = cyc;
            if (go_out) begin
                ok = 1'b1; gcyc = cyc; rs = ready_start;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rnd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            go_in = 1'($urandom);
            window_start = addr_t'($urandom);
            rnd_a = 16'($urandom); rnd_b = 16'($urandom); rnd_c = 16'($urandom);
            @(negedge clk);
            total++;
            if ({ifft_buf_addr, hann_rom_addr, out_ring_raddr, out_ring_waddr, out_ring_wdata,
                 out_ring_wren, go_out, ready_start, busy, overrun} !== '0) begin
                bad++;
                $display("FAIL reset_outputs cycle %0d: busy=%b wren=%b go_out=%b raddr=%h wdata=%h, required all zero",
                         k, busy, out_ring_wren, go_out, out_ring_raddr, out_ring_wdata);
            end
        end
        rnd_en = 1'b0;
        go_in = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_and_check(input string name, input addr_t ws, input logic [15:0] ring_v,
                                 input logic [15:0] ifft_v, input logic [15:0] hann_v,
                                 input logic [15:0] exp_old, input logic [15:0] exp_new);
        int c0, gcyc, fw, w0, g0, err_old, err_new;
        bit ok;
        addr_t rs;
        preload(ring_v, ifft_v, hann_v);
        w0 = wren_cnt; g0 = go_cnt;
        start_window(ws, c0);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL %s busy_after_go: got %b want 1", name, busy);
        end
        wait_go(ok, gcyc, fw, rs);
        total++;
        if (!ok) begin
            bad++; $display("FAIL %s go_out_timeout: no go_out within 6000 cycles", name);
        end
        total++;
        if (gcyc !== c0 + 4099) begin
            bad++; $display("FAIL %s go_out_latency: got %0d want %0d", name, gcyc - c0 - 1, 4098);
        end
        total++;
        if (fw !== c0 + 3) begin
            bad++; $display("FAIL %s first_wren: got %0d want %0d", name, fw - c0 - 1, 2);
        end
        total++;
        if (rs !== ws) begin
            bad++; $display("FAIL %s ready_start: got %0d want %0d", name, rs, ws);
        end
        repeat (3) @(negedge clk);
        total++;
        if (wren_cnt - w0 !== 4096) begin
            bad++; $display("FAIL %s wren_count: got %0d want 4096", name, wren_cnt - w0);
        end
        total++;
        if (go_cnt - g0 !== 1 || busy !== 1'b0) begin
            bad++; $display("FAIL %s go_count_idle: go=%0d busy=%b want go=1 busy=0",
                            name, go_cnt - g0, busy);
        end
        err_old = 0; err_new = 0;
        for (int i = 0; i < WINDOW_LEN; i++) begin
            addr_t slot;
            slot = ws + addr_t'(i);
            if (i < WINDOW_LEN - HOP) begin
                if (ring_mem[slot] !== exp_old) err_old++;
            end else begin
                if (ring_mem[slot] !== exp_new) err_new++;
            end
        end
        total++;
        if (err_old !== 0) begin
            bad++; $display("FAIL %s ring_overlap: %0d bad slots, slot %0d=%h want %h",
                            name, err_old, ws, ring_mem[ws], exp_old);
        end
        total++;
        if (err_new !== 0) begin
            bad++; $display("FAIL %s ring_newest_hop: %0d bad slots, slot %0d=%h want %h", name,
                            err_new, ws + addr_t'(3072), ring_mem[ws + addr_t'(3072)], exp_new);
        end
    endtask

    task automatic test_basic();
        run_and_check("basic", 12'd0, 16'h1000, 16'h4000, 16'h8000, 16'h3000, 16'h2000);
    endtask

    task automatic test_wrap();
        run_and_check("wrap", 12'd3072, 16'h1000, 16'h4000, 16'h8000, 16'h3000, 16'h2000);
    endtask

    task automatic test_saturation();
        run_and_check("sat_pos", 12'd0, 16'h7FFF, 16'h7FFF, 16'hFFFF, 16'h7FFF, 16'h7FFE);
        run_and_check("sat_neg", 12'd0, 16'h8000, 16'h8000, 16'hFFFF, 16'h8000, 16'h8000);
        run_and_check("no_sat", 12'd0, 16'h0000, 16'h7FFF, 16'hFFFF, 16'h7FFE, 16'h7FFE);
    endtask

    task automatic test_overrun();
        int c0, gcyc, fw, g0, err;
        bit ok;
        addr_t rs;
        preload(16'h1000, 16'h4000, 16'h8000);
        g0 = go_cnt;
        start_window(12'd0, c0);
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL overrun_before: got %b want 0", overrun);
        end
        repeat (498) @(negedge clk);
        go_in = 1'b1; window_start = 12'd7;
        @(negedge clk);
        go_in = 1'b0;
        total++;
        if (overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_set: got %b want 1", overrun);
        end
        wait_go(ok, gcyc, fw, rs);
        total++;
        if (!ok || gcyc !== c0 + 4099 || rs !== 12'd0) begin
            bad++; $display("FAIL overrun_go_out: ok=%b latency=%0d start=%0d want 1/4098/0",
                            ok, gcyc - c0 - 1, rs);
        end
        repeat (20) @(negedge clk);
        total++;
        if (go_cnt - g0 !== 1 || overrun !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL overrun_single: go=%0d overrun=%b busy=%b want 1/1/0",
                            go_cnt - g0, overrun, busy);
        end
        err = 0;
        for (int i = 0; i < WINDOW_LEN; i++) begin
            if (ring_mem[i] !== ((i < WINDOW_LEN - HOP) ? 16'h3000 : 16'h2000)) err++;
        end
        total++;
        if (err !== 0) begin
            bad++; $display("FAIL overrun_ring: %0d bad slots, slot 7=%h want 3000", err, ring_mem[7]);
        end
    endtask

    task automatic test_mid_reset();
        int c0, g0;
        bit hit;
        preload(16'h1000, 16'h4000, 16'h8000);
        g0 = go_cnt;
        start_window(12'd0, c0);
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (busy && ifft_buf_addr == 12'd100) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!hit) begin
            bad++; $display("FAIL midreset_index: index 100 not reached, addr=%0d", ifft_buf_addr);
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (out_ring_wren !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            bad++; $display("FAIL midreset_drop: wren=%b busy=%b overrun=%b want 0/0/0",
                            out_ring_wren, busy, overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4200) @(negedge clk);
        total++;
        if (go_cnt - g0 !== 0) begin
            bad++; $display("FAIL midreset_no_go: go pulses=%0d want 0", go_cnt - g0);
        end
        run_and_check("after_reset", 12'd1000, 16'h1000, 16'h4000, 16'h8000, 16'h3000, 16'h2000);
    endtask

    initial begin
        rst_n = 1'b0;
        go_in = 1'b0;
        window_start = '0;
        rnd_a = '0; rnd_b = '0; rnd_c = '0;
        preload(16'h0000, 16'h0000, 16'h0000);
        test_reset();
        test_basic();
        test_wrap();
        test_saturation();
        test_overrun();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
